cdm_sweep_ctrl: RTL and testbench
=================================

Name: cdm_sweep_ctrl

Overview:
- Sequencer that drives one 8x8 carry-disregard approximate multiplier through every operand pair (A outer loop, B inner loop).
- Compares each product against the exact product and accumulates error statistics: error count, sum of error distances, maximum error distance with its operands.
- Emits a per-pair result stream for a logger.
- Sits between a host/test harness and the multiplier under characterization; replaces file-based exhaustive sweeps with on-chip measurement.

Parameters:
- WIDTH, 8, operand width; the sweep covers N = 2^(2*WIDTH) pairs.
- LAT, 0, multiplier latency in cycles. 0 means combinational; result for operands presented in cycle t is sampled at the end of cycle t+LAT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; honoured only in IDLE
- abort  in  1  terminate sweep; honoured in RUN/DRAIN
- mul_a  out  WIDTH  operand A to multiplier (registered)
- mul_b  out  WIDTH  operand B to multiplier (registered)
- mul_r  in  2*WIDTH  multiplier result
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse, sweep complete
- out_valid  out  1  per-pair record valid (no backpressure)
- out_a, out_b  out  WIDTH  operands of record
- out_r  out  2*WIDTH  approximate result of record
- out_ed  out  2*WIDTH  error distance |A*B - R| of record
- err_cnt  out  2*WIDTH+1  pairs with ED != 0
- sum_ed  out  4*WIDTH  sum of ED
- max_ed  out  2*WIDTH  largest ED
- max_a, max_b  out  WIDTH  operands of first pair reaching max_ed

Behaviour:
- Reset: state IDLE; every output zero, including all statistics.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - DRAIN lasts LAT cycles; it is skipped when LAT=0.
  - DONE lasts exactly one cycle.
- Start (edge E0, state IDLE, start=1):
  - enter RUN; pair index k=0; mul_a=mul_b=0.
  - clear err_cnt, sum_ed, max_ed, max_a, max_b.
- Pair ordering: mul_a = k[2*WIDTH-1:WIDTH], mul_b = k[WIDTH-1:0].
- Issue: pair k is presented during cycle k+1 after E0.
  - One pair is issued per cycle; k increments each edge in RUN.
  - After pair N-1: go to DRAIN if LAT>0, else DONE.
  - mul_a/mul_b hold the last pair outside RUN.
- Operand alignment: a LAT-deep delay line carries (a, b, valid) alongside the multiplier pipeline.
- Evaluation: pair k is evaluated at edge E(k+1+LAT).
  - Exact product a*b is 2*WIDTH bits; ED = |exact - mul_r| uses unsigned compare/subtract.
  - The same edge registers out_valid=1 and out_a/b/r/ed for one cycle.
  - err_cnt increments if ED != 0; sum_ed += ED.
  - If ED > max_ed (strictly greater), update max_ed, max_a, max_b. Ties keep the earliest pair.
- Sum width: 4*WIDTH bits cannot overflow, since N*(2^(2W)-1) < 2^(4W).
- Completion: the last evaluation edge E(N+LAT) enters DONE.
  - done=1 and busy=0 in the following cycle.
  - Statistics are final and stable from then until the next accepted start.
- busy: high from the cycle after E0 through the cycle before DONE.
- start while busy or in DONE: ignored.
- Abort in RUN/DRAIN:
  - next state IDLE; busy=0 next cycle; no done pulse.
  - In-flight pairs are discarded: no out_valid for them.
  - Partial statistics hold.
  - Abort has priority over completion on the same edge.
- Simultaneous start+abort in IDLE: start wins.
- rst has priority over everything, including mid-sweep; all outputs return to zero.

Test Plan:
- Exact model (mul_r=A*B, LAT=0), start once:
  - Expect err_cnt=0, sum_ed=0, max_ed=0, max_a=max_b=0.
  - done rises 65536 cycles after start edge; exactly 65536 out_valid pulses.
  - First record (0,0), last record (255,255).
- LSB-dropping model (mul_r=(A*B)&16'hFFFE):
  - Expect err_cnt=16384, sum_ed=16384, max_ed=1, max_a=1, max_b=1.
- Zero model (mul_r=0):
  - Expect err_cnt=65025, sum_ed=1065369600, max_ed=65025, max_a=255, max_b=255.
- LAT=2 model (two-stage registered exact multiplier):
  - Zero error.
  - done exactly 65538 cycles after start edge.
  - out_a/out_b of each record match the delayed operands.
- Abort during pair k=100 (LAT=0, zero model):
  - busy low next cycle; no done pulse.
  - Statistics frozen at their partial values.
  - New start clears the statistics and restarts from (0,0).
- rst asserted mid-RUN, plus start pulsed while busy:
  - rst: all outputs zero the next cycle.
  - start while busy: no restart, sweep ordering unaffected.

Source files
------------

// File: rtl/cdm_sweep_ctrl_if.sv
// cdm_sweep_ctrl_if: host, multiplier and logger signal bundle of the sweep controller
interface cdm_sweep_ctrl_if #(parameter int WIDTH = 8);
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_r;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_b;
  logic [2*WIDTH-1:0]   out_r;
  logic [2*WIDTH-1:0]   out_ed;
  logic [2*WIDTH:0]     err_cnt;
  logic [4*WIDTH-1:0]   sum_ed;
  logic [2*WIDTH-1:0]   max_ed;
  logic [WIDTH-1:0]     max_a;
  logic [WIDTH-1:0]     max_b;
  modport slave (
    input  start, abort, mul_r,
    output busy, done, mul_a, mul_b, out_valid, out_a, out_b, out_r, out_ed,
           err_cnt, sum_ed, max_ed, max_a, max_b
  );
  modport master (
    output start, abort, mul_r,
    input  busy, done, mul_a, mul_b, out_valid, out_a, out_b, out_r, out_ed,
           err_cnt, sum_ed, max_ed, max_a, max_b
  );
endinterface

// File: rtl/cdm_sweep_ctrl.sv
// cdm_sweep_ctrl: exhaustive operand sweep of an approximate multiplier with on-chip error statistics
module cdm_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0
) (
  input logic            clk,
  input logic            rst,
  cdm_sweep_ctrl_if.slave sw
);
  localparam int KW = 2 * WIDTH;
  localparam int EW = KW + 1;
  localparam int SW = 4 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t          r_state, w_next;
  logic [KW-1:0]   r_k;
  logic            w_start, w_abort, w_ev_raw, w_ev, w_last_k, w_last_ev, w_busy, w_done;
  logic [WIDTH-1:0] w_ea, w_eb;
  logic [KW-1:0]   w_ex, w_ed;
  logic            r_ov;
  logic [WIDTH-1:0] r_oa, r_ob, r_ma, r_mb;
  logic [KW-1:0]   r_or, r_oed, r_max;
  logic [EW-1:0]   r_err;
  logic [SW-1:0]   r_sum;
  assign w_start   = (r_state == IDLE) && sw.start;
  assign w_abort   = w_busy && sw.abort;
  assign w_ev      = w_ev_raw && !w_abort;
  assign w_last_k  = &r_k;
  assign w_last_ev = w_ev && (&{w_ea, w_eb});
  assign w_ex      = KW'(w_ea) * KW'(w_eb);
  assign w_ed      = (w_ex >= sw.mul_r) ? w_ex - sw.mul_r : sw.mul_r - w_ex;
  generate
    if (LAT == 0) begin : g_comb
      assign w_ea     = r_k[KW-1:WIDTH];
      assign w_eb     = r_k[WIDTH-1:0];
      assign w_ev_raw = r_state == RUN;
    end else begin : g_dl
      logic [KW:0] r_dl [LAT];
      // operands ride alongside the multiplier pipeline; abort flushes pairs still in flight
      always_ff @(posedge clk)
        if (rst || w_abort) for (int i = 0; i < LAT; i++) r_dl[i] <= '0;
        else begin
          r_dl[0] <= {r_state == RUN, r_k};
          for (int i = 1; i < LAT; i++) r_dl[i] <= r_dl[i-1];
        end
      assign {w_ev_raw, w_ea, w_eb} = r_dl[LAT-1];
    end
  endgenerate
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state: abort beats completion, completion follows the final evaluation
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = sw.start ? RUN : IDLE;
      RUN:     w_next = sw.abort ? IDLE : w_last_ev ? DONE : w_last_k ? DRAIN : RUN;
      DRAIN:   w_next = sw.abort ? IDLE : w_last_ev ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // state-decoded status outputs
  always_comb begin
    w_busy = (r_state == RUN) || (r_state == DRAIN);
    w_done = r_state == DONE;
  end
  // pair index: one pair per RUN cycle, holding the last pair once issue stops
  always_ff @(posedge clk)
    if (rst || w_start) r_k <= '0;
    else if (r_state == RUN && !w_last_k && !sw.abort) r_k <= r_k + KW'(1);
  // per-pair record and running statistics, cleared by an accepted start
  always_ff @(posedge clk)
    if (rst) begin
      r_ov  <= 1'b0;
      r_oa  <= '0;
      r_ob  <= '0;
      r_or  <= '0;
      r_oed <= '0;
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
      r_ma  <= '0;
      r_mb  <= '0;
    end else begin
      r_ov <= w_ev;
      if (w_start) begin
        r_err <= '0;
        r_sum <= '0;
        r_max <= '0;
        r_ma  <= '0;
        r_mb  <= '0;
      end else if (w_ev) begin
        r_oa  <= w_ea;
        r_ob  <= w_eb;
        r_or  <= sw.mul_r;
        r_oed <= w_ed;
        r_err <= r_err + EW'(w_ed != '0);
        r_sum <= r_sum + SW'(w_ed);
        if (w_ed > r_max) begin
          r_max <= w_ed;
          r_ma  <= w_ea;
          r_mb  <= w_eb;
        end
      end
    end
  assign sw.busy      = w_busy;
  assign sw.done      = w_done;
  assign sw.mul_a     = r_k[KW-1:WIDTH];
  assign sw.mul_b     = r_k[WIDTH-1:0];
  assign sw.out_valid = r_ov;
  assign sw.out_a     = r_oa;
  assign sw.out_b     = r_ob;
  assign sw.out_r     = r_or;
  assign sw.out_ed    = r_oed;
  assign sw.err_cnt   = r_err;
  assign sw.sum_ed    = r_sum;
  assign sw.max_ed    = r_max;
  assign sw.max_a     = r_ma;
  assign sw.max_b     = r_mb;
endmodule

// File: tb/tb_cdm_sweep_ctrl.sv
// tb_cdm_sweep_ctrl: scoreboard bench for the sweep controller with exact, lossy and pipelined multipliers
module tb_cdm_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int m8 = 2;
  int m4 = 0;
  logic [2:0] start_v = '0;
  logic [2:0] abort_v = '0;
  logic [2:0] busy_v, done_v, nz_v;
  logic [63:0] err_v [3];
  logic [63:0] sum_v [3];
  logic [63:0] max_v [3];
  logic [63:0] ma_v  [3];
  logic [63:0] mb_v  [3];
  logic [63:0] mula_v[3];
  logic [63:0] mulb_v[3];
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [15:0] p8;
  logic [7:0]  p4, p2a, p2b;
  always #5 clk = ~clk;
  cdm_sweep_ctrl_if #(.WIDTH(8)) i8 ();
  cdm_sweep_ctrl_if #(.WIDTH(4)) i4 ();
  cdm_sweep_ctrl_if #(.WIDTH(4)) il ();
  cdm_sweep_ctrl #(.WIDTH(8), .LAT(0)) u8 (.clk(clk), .rst(rst), .sw(i8));
  cdm_sweep_ctrl #(.WIDTH(4), .LAT(0)) u4 (.clk(clk), .rst(rst), .sw(i4));
  cdm_sweep_ctrl #(.WIDTH(4), .LAT(2)) ul (.clk(clk), .rst(rst), .sw(il));
  assign p8 = 16'(i8.mul_a) * 16'(i8.mul_b);
  assign p4 = 8'(i4.mul_a) * 8'(i4.mul_b);
  assign i8.mul_r = (m8 == 0) ? p8 : (m8 == 1) ? (p8 & 16'hFFFE) : 16'h0;
  assign i4.mul_r = (m4 == 0) ? p4 : (m4 == 1) ? (p4 & 8'hFE) : 8'h0;
  always @(posedge clk) begin
    p2a <= 8'(il.mul_a) * 8'(il.mul_b);
    p2b <= p2a;
  end
  assign il.mul_r = p2b;
  assign {il.start, i4.start, i8.start} = start_v;
  assign {il.abort, i4.abort, i8.abort} = abort_v;
  assign busy_v = {il.busy, i4.busy, i8.busy};
  assign done_v = {il.done, i4.done, i8.done};
  assign nz_v[0] = |{i8.busy, i8.done, i8.mul_a, i8.mul_b, i8.out_valid, i8.out_a, i8.out_b, i8.out_r, i8.out_ed, i8.err_cnt, i8.sum_ed, i8.max_ed, i8.max_a, i8.max_b};
  assign nz_v[1] = |{i4.busy, i4.done, i4.mul_a, i4.mul_b, i4.out_valid, i4.out_a, i4.out_b, i4.out_r, i4.out_ed, i4.err_cnt, i4.sum_ed, i4.max_ed, i4.max_a, i4.max_b};
  assign nz_v[2] = |{il.busy, il.done, il.mul_a, il.mul_b, il.out_valid, il.out_a, il.out_b, il.out_r, il.out_ed, il.err_cnt, il.sum_ed, il.max_ed, il.max_a, il.max_b};
  assign err_v[0] = 64'(i8.err_cnt);
  assign err_v[1] = 64'(i4.err_cnt);
  assign err_v[2] = 64'(il.err_cnt);
  assign sum_v[0] = 64'(i8.sum_ed);
  assign sum_v[1] = 64'(i4.sum_ed);
  assign sum_v[2] = 64'(il.sum_ed);
  assign max_v[0] = 64'(i8.max_ed);
  assign max_v[1] = 64'(i4.max_ed);
  assign max_v[2] = 64'(il.max_ed);
  assign ma_v[0] = 64'(i8.max_a);
  assign ma_v[1] = 64'(i4.max_a);
  assign ma_v[2] = 64'(il.max_a);
  assign mb_v[0] = 64'(i8.max_b);
  assign mb_v[1] = 64'(i4.max_b);
  assign mb_v[2] = 64'(il.max_b);
  assign mula_v[0] = 64'(i8.mul_a);
  assign mula_v[1] = 64'(i4.mul_a);
  assign mula_v[2] = 64'(il.mul_a);
  assign mulb_v[0] = 64'(i8.mul_b);
  assign mulb_v[1] = 64'(i4.mul_b);
  assign mulb_v[2] = 64'(il.mul_b);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // expected records {a, b, r, ed}, each field 16 bits, for the first n pairs of a sweep
  task automatic push(input int s, input int mode, input int w, input int n);
    int a, b, p, r;
    logic [63:0] rec;
    for (int k = 0; k < n; k++) begin
      a = k >> w;
      b = k & ((1 << w) - 1);
      p = a * b;
      r = (mode == 0) ? p : (mode == 1) ? (p & ~1) : 0;
      rec = {a[15:0], b[15:0], r[15:0], 16'(p - r)};
      if (s == 0) q0.push_back(rec);
      else if (s == 1) q1.push_back(rec);
      else q2.push_back(rec);
    end
  endtask
  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
  endfunction
  always @(negedge clk)
    if (i8.out_valid) begin
      if (q0.size() == 0) chk("u8_extra_record", 64'd1, 64'd0);
      else chk("u8_record", {16'(i8.out_a), 16'(i8.out_b), 16'(i8.out_r), 16'(i8.out_ed)}, q0.pop_front());
    end
  always @(negedge clk)
    if (i4.out_valid) begin
      if (q1.size() == 0) chk("u4_extra_record", 64'd1, 64'd0);
      else chk("u4_record", {16'(i4.out_a), 16'(i4.out_b), 16'(i4.out_r), 16'(i4.out_ed)}, q1.pop_front());
    end
  always @(negedge clk)
    if (il.out_valid) begin
      if (q2.size() == 0) chk("ul_extra_record", 64'd1, 64'd0);
      else chk("ul_record", {16'(il.out_a), 16'(il.out_b), 16'(il.out_r), 16'(il.out_ed)}, q2.pop_front());
    end
  task automatic sweep(input int s, input int mode, input int w, input int lat, input int pulse_at,
                       input longint e_err, input longint e_sum, input longint e_max,
                       input longint e_ma, input longint e_mb);
    int n, cyc;
    n = 1 << (2 * w);
    if (s == 0) m8 = mode;
    else if (s == 1) m4 = mode;
    @(posedge clk);
    #1 start_v[s] = 1'b1;
    push(s, mode, w, n);
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    chk("start_busy", 64'(busy_v[s]), 64'd1);
    chk("start_mul_a", mula_v[s], 64'd0);
    chk("start_mul_b", mulb_v[s], 64'd0);
    chk("start_clear_err", err_v[s], 64'd0);
    chk("start_clear_max", max_v[s], 64'd0);
    cyc = 0;
    while (!done_v[s] && cyc < n + lat + 20) begin
      @(posedge clk);
      #1 cyc++;
      start_v[s] = (cyc == pulse_at);
    end
    chk("done_latency", 64'(cyc), 64'(n + lat));
    chk("done_busy_low", 64'(busy_v[s]), 64'd0);
    chk("err_cnt", err_v[s], 64'(e_err));
    chk("sum_ed", sum_v[s], 64'(e_sum));
    chk("max_ed", max_v[s], 64'(e_max));
    chk("max_a", ma_v[s], 64'(e_ma));
    chk("max_b", mb_v[s], 64'(e_mb));
    start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    chk("done_one_cycle", 64'(done_v[s]), 64'd0);
    @(posedge clk);
    #1 chk("start_in_done_ignored", 64'(busy_v[s]), 64'd0);
    chk("records_all_seen", 64'(qsize(s)), 64'd0);
    chk("err_cnt_stable", err_v[s], 64'(e_err));
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 chk("reset_u8_zero", 64'(nz_v[0]), 64'd0);
    chk("reset_u4_zero", 64'(nz_v[1]), 64'd0);
    chk("reset_ul_zero", 64'(nz_v[2]), 64'd0);
    rst = 1'b0;
    sweep(1, 0, 4, 0, 50, 0, 0, 0, 0, 0);
    sweep(1, 1, 4, 0, -1, 64, 64, 1, 1, 1);
    sweep(1, 2, 4, 0, -1, 225, 14400, 225, 15, 15);
    m4 = 2;
    @(posedge clk);
    #1 start_v[1] = 1'b1;
    push(1, 2, 4, 100);
    @(posedge clk);
    #1 start_v[1] = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk("abort_pair_a", mula_v[1], 64'd6);
    chk("abort_pair_b", mulb_v[1], 64'd4);
    abort_v[1] = 1'b1;
    @(posedge clk);
    #1 abort_v[1] = 1'b0;
    chk("abort_busy_low", 64'(busy_v[1]), 64'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 seen += int'(done_v[1]) + int'(busy_v[1]);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_err_cnt", err_v[1], 64'd78);
    chk("abort_sum_ed", sum_v[1], 64'd1836);
    chk("abort_max_ed", max_v[1], 64'd75);
    chk("abort_max_a", ma_v[1], 64'd5);
    chk("abort_max_b", mb_v[1], 64'd15);
    chk("abort_no_inflight_record", 64'(q1.size()), 64'd0);
    sweep(1, 2, 4, 0, -1, 225, 14400, 225, 15, 15);
    m4 = 1;
    @(posedge clk);
    #1 start_v[1] = 1'b1;
    push(1, 1, 4, 256);
    @(posedge clk);
    #1 start_v[1] = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("midrun_busy", 64'(busy_v[1]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrun_reset_zero", 64'(nz_v[1]), 64'd0);
    q1.delete();
    @(posedge clk);
    #1 chk("after_reset_idle", 64'(busy_v[1]), 64'd0);
    sweep(1, 0, 4, 0, 7, 0, 0, 0, 0, 0);
    sweep(2, 0, 4, 2, 30, 0, 0, 0, 0, 0);
    sweep(0, 2, 8, 0, -1, 65025, 1065369600, 65025, 255, 255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
